// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first unsigned subtractor.
// Computes D = (A - B - Bin) mod 2^WIDTH and Bout = (A < B + Bin), one
// full-subtractor step per clock, and pulses Done when the result is ready.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for Start; operands are latched on the accepting edge
//   SHIFT | one bit per edge, LSB first; leaves after bit WIDTH-1
//   DONE  | D/Bout hold the new result; Done is high for this single cycle
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  // The counter has to hold WIDTH itself, because it is incremented on the
  // last bit too; sizing it for WIDTH+1 values means it never wraps.
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  // Full-subtractor cell on the current LSBs plus the next result image.
  always_comb begin
    a_i     = a_sr[0];
    b_i     = b_sr[0];
    d_i     = a_i ^ b_i ^ br;
    br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    r_next  = {d_i, r_sr[WIDTH-1:1]};
  end

  // Sequencer: operand/result shifting, bit count and registered outputs.
  // D and Bout only change on the final SHIFT edge, so no partial result is
  // ever visible on them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            r_sr  <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            D     <= r_next;
            Bout  <= br_next;
            Done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed scenarios
// plus a randomized regression against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             RST;
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .D     (D),
    .Bout  (Bout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: plain unsigned arithmetic.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic bin, output logic [WIDTH-1:0] d, output logic bo);
    int diff;
    diff = int'(a) - int'(b) - int'(bin);
    d    = diff[WIDTH-1:0];
    bo   = (int'(a) < (int'(b) + int'(bin)));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issues one operation from IDLE and observes it for WIDTH+4 edges.
  // Reports the result seen with Done, the edge offset of Done, how many
  // Done pulses appeared, whether D/Bout moved before Done, and whether
  // Busy was seen once the op should have finished.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                       input bit noise, output logic [WIDTH-1:0] d_obs, output logic bo_obs,
                       output int lat, output int ndone, output bit glitch, output bit late_busy);
    logic [WIDTH-1:0] d0;
    logic             b0;
    d0 = D; b0 = Bout;
    d_obs = D; bo_obs = Bout;
    lat = -1; ndone = 0; glitch = 0; late_busy = 0;
    A = a; B = b; Bin = bin; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); Bin = 1'($urandom);
    for (int j = 1; j <= WIDTH + 4; j++) begin
      if (noise) Start = (j <= WIDTH) ? 1'($urandom) : 1'b0;
      tick();
      if (Done) begin
        ndone++;
        if (lat < 0) lat = j;
        d_obs = D; bo_obs = Bout;
      end else if (lat < 0 && (D !== d0 || Bout !== b0)) begin
        glitch = 1;
      end
      if (j >= WIDTH + 1 && Busy) late_busy = 1;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b1; A = 8'hAA; B = 8'h11; Bin = 1'b1;
    repeat (3) tick();
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: Busy=%b Done=%b required 0 0", Busy, Done);
    end
    checks++;
    if (D !== 8'h00 || Bout !== 1'b0) begin
      failures++;
      $display("FAIL reset_result: D=%h Bout=%b required 00 0", D, Bout);
    end
    Start = 1'b0; RST = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: Busy=%b required 0", Busy);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] d; logic bo; int lat, nd; bit gl, lb;
    do_op(8'h05, 8'h03, 1'b0, 0, d, bo, lat, nd, gl, lb);
    checks++;
    if (lat !== WIDTH || nd !== 1) begin
      failures++;
      $display("FAIL basic_latency: done_offset=%0d pulses=%0d required %0d 1", lat, nd, WIDTH);
    end
    checks++;
    if (d !== 8'h02 || bo !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: D=%h Bout=%b required 02 0", d, bo);
    end
    checks++;
    if (gl || lb) begin
      failures++;
      $display("FAIL basic_hold: early_change=%0d busy_after=%0d required 0 0", gl, lb);
    end
  endtask

  task automatic test_borrow_edges();
    logic [WIDTH-1:0] d; logic bo; int lat, nd; bit gl, lb;
    do_op(8'h00, 8'h01, 1'b0, 0, d, bo, lat, nd, gl, lb);
    checks++;
    if (d !== 8'hFF || bo !== 1'b1 || nd !== 1) begin
      failures++;
      $display("FAIL underflow: D=%h Bout=%b pulses=%0d required FF 1 1", d, bo, nd);
    end
    do_op(8'hFF, 8'hFF, 1'b1, 0, d, bo, lat, nd, gl, lb);
    checks++;
    if (d !== 8'hFF || bo !== 1'b1 || nd !== 1) begin
      failures++;
      $display("FAIL equal_with_bin: D=%h Bout=%b pulses=%0d required FF 1 1", d, bo, nd);
    end
  endtask

  task automatic test_start_held();
    int acc[$]; int ndone; bit prev_busy;
    A = 8'h80; B = 8'h7F; Bin = 1'b1; Start = 1'b1;
    prev_busy = Busy; ndone = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (Busy && !prev_busy) acc.push_back(c);
      if (Done) ndone++;
      prev_busy = Busy;
    end
    Start = 1'b0;
    checks++;
    if (acc.size() != 4) begin
      failures++;
      $display("FAIL held_accepts: count=%0d required 4", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != WIDTH + 2) begin
        failures++;
        $display("FAIL held_interval: interval=%0d required %0d", acc[i] - acc[i-1], WIDTH + 2);
      end
    end
    checks++;
    if (ndone != 3 || D !== 8'h00 || Bout !== 1'b0) begin
      failures++;
      $display("FAIL held_result: pulses=%0d D=%h Bout=%b required 3 00 0", ndone, D, Bout);
    end
    repeat (WIDTH + 3) tick();
  endtask

  task automatic test_ignore_start();
    logic [WIDTH-1:0] ed; logic eb; int nd; int lat; bit late;
    model(8'h3C, 8'h15, 1'b0, ed, eb);
    A = 8'h3C; B = 8'h15; Bin = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0; nd = 0; lat = -1; late = 0;
    for (int j = 1; j <= WIDTH + 6; j++) begin
      if (j == 4) begin Start = 1'b1; A = 8'h01; B = 8'h02; Bin = 1'b1; end
      else Start = 1'b0;
      tick();
      if (Done) begin nd++; if (lat < 0) lat = j; end
      if (j >= WIDTH + 1 && Busy) late = 1;
    end
    checks++;
    if (nd != 1 || lat != WIDTH || late) begin
      failures++;
      $display("FAIL ignore_done: pulses=%0d offset=%0d busy_after=%0d required 1 %0d 0", nd, lat, late, WIDTH);
    end
    checks++;
    if (D !== ed || Bout !== eb) begin
      failures++;
      $display("FAIL ignore_result: D=%h Bout=%b required %h %b", D, Bout, ed, eb);
    end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] d; logic bo; int lat, nd; bit gl, lb; int dseen;
    A = 8'hC3; B = 8'h21; Bin = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || D !== 8'h00 || Bout !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: Busy=%b Done=%b D=%h Bout=%b required 0 0 00 0", Busy, Done, D, Bout);
    end
    dseen = 0;
    for (int j = 0; j < WIDTH + 4; j++) begin
      tick();
      if (Done || Busy) dseen++;
    end
    checks++;
    if (dseen != 0) begin
      failures++;
      $display("FAIL abort_quiet: active_cycles=%0d required 0", dseen);
    end
    do_op(8'h10, 8'h01, 1'b0, 0, d, bo, lat, nd, gl, lb);
    checks++;
    if (d !== 8'h0F || bo !== 1'b0 || nd !== 1 || lat != WIDTH) begin
      failures++;
      $display("FAIL after_abort: D=%h Bout=%b pulses=%0d offset=%0d required 0F 0 1 %0d", d, bo, nd, lat, WIDTH);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, d, ed; logic bin, bo, eb; int lat, nd; bit gl, lb; int bad;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      model(a, b, bin, ed, eb);
      do_op(a, b, bin, 1, d, bo, lat, nd, gl, lb);
      checks++;
      if (d !== ed || bo !== eb || lat != WIDTH || nd != 1 || gl || lb) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_op: A=%h B=%h Bin=%b got D=%h Bout=%b offset=%0d pulses=%0d early=%0d late=%0d required D=%h Bout=%b offset=%0d pulses=1",
                   a, b, bin, d, bo, lat, nd, gl, lb, ed, eb, WIDTH);
        bad++;
      end
    end
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow_edges();
    test_start_held();
    test_ignore_start();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
